// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module  : mips_mem_pkg
// Brief   : Shared types and constants for the data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int LANE_W = 8;
    localparam int WORD_W = 32;

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
// ============================================================================
// Module  : dmem_lane
// Brief   : Byte-lane merge for stores and extract/sign-extend for loads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lane
    import mips_mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [1:0]        lane,
    input  logic              is_byte,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] store_word,
    output logic [WORD_W-1:0] load_word
);

    logic [LANE_W-1:0] w_sel_byte;

    always_comb begin
        w_sel_byte = old_word[{lane, 3'b000} +: LANE_W];
        store_word = wdata;
        load_word  = old_word;
        if (is_byte) begin
            // Little-endian: lane 0 is bits [7:0]; other lanes are preserved.
            store_word                           = old_word;
            store_word[{lane, 3'b000} +: LANE_W] = wdata[LANE_W-1:0];
            load_word = {{(WORD_W-LANE_W){w_sel_byte[LANE_W-1]}}, w_sel_byte};
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module  : dmem_responder
// Brief   : Fixed-latency load/store responder with pipeline stall output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_COUNT = CW'(LATENCY - 1);

    dmem_state_t        r_state;
    dmem_state_t        w_next_state;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      w_count_dec;
    logic               r_we;
    logic               r_byte;
    logic [AW+1:0]      r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic [WORD_W-1:0]  r_mem [DEPTH_WORDS];

    logic               w_access;
    logic               w_acc_we;
    logic               w_acc_byte;
    logic [AW+1:0]      w_acc_addr;
    logic [WORD_W-1:0]  w_acc_wdata;
    logic               w_misaligned;
    logic [AW-1:0]      w_index;
    logic [WORD_W-1:0]  w_old_word;
    logic [WORD_W-1:0]  w_store_word;
    logic [WORD_W-1:0]  w_load_word;
    logic               w_unused;

    // Upper address bits are ignored, so addresses wrap over the array.
    assign w_unused = ^req_addr[31:AW+2];

    // A single-cycle latency accesses straight from the request inputs.
    always_comb begin
        w_acc_we    = r_we;
        w_acc_byte  = r_byte;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_acc_we    = req_we;
            w_acc_byte  = req_byte;
            w_acc_addr  = req_addr[AW+1:0];
            w_acc_wdata = req_wdata;
        end
    end

    assign w_misaligned = ~w_acc_byte & (w_acc_addr[1:0] != 2'b00);
    assign w_index      = w_acc_addr[AW+1:2];
    assign w_old_word   = r_mem[w_index];
    assign w_count_dec  = r_count - CW'(1);

    dmem_lane u_lane (
        .old_word   (w_old_word),
        .lane       (w_acc_addr[1:0]),
        .is_byte    (w_acc_byte),
        .wdata      (w_acc_wdata),
        .store_word (w_store_word),
        .load_word  (w_load_word)
    );

    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        req_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_access     = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // Access fires on the edge where the decremented count hits zero.
                if (w_count_dec == '0) begin
                    w_access     = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign resp_valid = (r_state == RESP);
    assign stall      = req_valid & ~resp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_byte     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && req_valid) begin
                r_we    <= req_we;
                r_byte  <= req_byte;
                r_addr  <= req_addr[AW+1:0];
                r_wdata <= req_wdata;
                r_count <= LOAD_COUNT;
            end else if (r_state == WAIT) begin
                r_count <= w_count_dec;
            end
            if (w_access) begin
                resp_rdata <= (w_acc_we | w_misaligned) ? '0 : w_load_word;
                resp_err   <= w_misaligned;
            end
        end
    end

    // Array is not reset; reset also blocks any uncommitted store.
    always_ff @(posedge clk) begin
        if (!reset && w_access && w_acc_we && !w_misaligned) begin
            r_mem[w_index] <= w_store_word;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed and randomized checks of dmem_responder (LATENCY 3 and 1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv3, rv1, we, bt;
    logic [31:0] addr, wdata;
    logic        ready3, valid3, err3, stall3;
    logic        ready1, valid1, err1, stall1;
    logic [31:0] rdata3, rdata1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_we(we), .req_byte(bt),
        .req_addr(addr), .req_wdata(wdata), .req_ready(ready3), .resp_valid(valid3),
        .resp_rdata(rdata3), .resp_err(err3), .stall(stall3)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_we(we), .req_byte(bt),
        .req_addr(addr), .req_wdata(wdata), .req_ready(ready1), .resp_valid(valid1),
        .resp_rdata(rdata1), .resp_err(err1), .stall(stall1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request to the selected DUT and check handshake timing.
    task automatic do_req(input bit one, input bit w, input bit b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er);
        int  lat_exp;
        int  cyc;
        bit  got;
        logic s_ready, s_stall, s_valid;
        lat_exp = one ? 1 : 3;
        @(negedge clk);
        we = w; bt = b; addr = a; wdata = d;
        if (one) rv1 = 1'b1; else rv3 = 1'b1;
        #1;
        s_ready = one ? ready1 : ready3;
        s_stall = one ? stall1 : stall3;
        s_valid = one ? valid1 : valid3;
        checks++;
        if (s_ready !== 1'b1 || s_stall !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL accept_cycle: ready=%b stall=%b valid=%b, required 1 1 0",
                     s_ready, s_stall, s_valid);
        end
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            s_ready = one ? ready1 : ready3;
            s_stall = one ? stall1 : stall3;
            s_valid = one ? valid1 : valid3;
            if (s_valid === 1'b1) begin
                got = 1;
            end else begin
                checks++;
                if (s_ready !== 1'b0 || s_stall !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_cycle %0d: ready=%b stall=%b, required 0 1",
                             cyc, s_ready, s_stall);
                end
            end
        end
        checks++;
        if (!got || cyc != lat_exp) begin
            errors++;
            $display("FAIL latency: got %0d cycles (seen=%0d), required %0d", cyc, got, lat_exp);
        end
        if (got) begin
            checks++;
            if (s_ready !== 1'b0 || s_stall !== 1'b0) begin
                errors++;
                $display("FAIL resp_cycle: ready=%b stall=%b, required 0 0", s_ready, s_stall);
            end
        end
        rd = one ? rdata1 : rdata3;
        er = one ? err1 : err3;
        rv1 = 1'b0; rv3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (valid3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0 || ready3 !== 1'b1 || stall3 !== 1'b0) begin
            errors++;
            $display("FAIL reset3: valid=%b rdata=%h err=%b ready=%b stall=%b, required 0 0 0 1 0",
                     valid3, rdata3, err3, ready3, stall3);
        end
        checks++;
        if (valid1 !== 1'b0 || rdata1 !== 32'h0 || err1 !== 1'b0 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL reset1: valid=%b rdata=%h err=%b ready=%b, required 0 0 0 1",
                     valid1, rdata1, err1, ready1);
        end
        reset = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er;
        do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL sw_resp: rdata=%h err=%b, required 0 0", rd, er);
        end
        do_req(0, 0, 0, 32'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL lw_10: rdata=%h err=%b, required deadbeef 0", rd, er);
        end
        @(negedge clk);
        checks++;
        if (valid3 !== 1'b0 || rdata3 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold: valid=%b rdata=%h, required 0 deadbeef", valid3, rdata3);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er;
        do_req(0, 1, 0, 32'h10, 32'h11223344, rd, er);
        do_req(0, 1, 1, 32'h13, 32'h0000AB80, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL sb_resp: rdata=%h err=%b, required 0 0", rd, er);
        end
        do_req(0, 0, 0, 32'h10, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h80223344) begin
            errors++; $display("FAIL sb_merge: rdata=%h, required 80223344", rd);
        end
        do_req(0, 0, 1, 32'h13, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            errors++; $display("FAIL lb_13: rdata=%h err=%b, required ffffff80 0", rd, er);
        end
        do_req(0, 0, 1, 32'h12, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h00000022) begin
            errors++; $display("FAIL lb_12: rdata=%h, required 00000022", rd);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er;
        do_req(0, 1, 0, 32'h04, 32'hA5A5A5A5, rd, er);
        do_req(0, 0, 0, 32'h06, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            errors++; $display("FAIL lw_misaligned: rdata=%h err=%b, required 0 1", rd, er);
        end
        do_req(0, 1, 0, 32'h06, 32'h12345678, rd, er);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("FAIL sw_misaligned: err=%b, required 1", er);
        end
        do_req(0, 0, 0, 32'h04, 32'h0, rd, er);
        checks++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
            errors++; $display("FAIL misaligned_nowrite: rdata=%h err=%b, required a5a5a5a5 0", rd, er);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er;
        do_req(0, 1, 0, 32'h0, 32'h5, rd, er);
        do_req(0, 0, 0, DEPTH * 4, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h5) begin
            errors++; $display("FAIL wrap3: rdata=%h, required 5", rd);
        end
        do_req(1, 1, 0, 32'h8, 32'h00000077, rd, er);
        do_req(1, 0, 0, 32'h8 + DEPTH * 4, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h77 || er !== 1'b0) begin
            errors++; $display("FAIL wrap1: rdata=%h err=%b, required 77 0", rd, er);
        end
        do_req(1, 0, 1, 32'h8, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h77) begin
            errors++; $display("FAIL lb_lat1: rdata=%h, required 77", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er;
        bit bad;
        do_req(0, 1, 0, 32'h20, 32'h1, rd, er);
        @(negedge clk);
        we = 1'b1; bt = 1'b0; addr = 32'h20; wdata = 32'hCAFE0000; rv3 = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ready3 !== 1'b1 || valid3 !== 1'b0 || rdata3 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: ready=%b valid=%b rdata=%h, required 1 0 0",
                     ready3, valid3, rdata3);
        end
        rv3 = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (valid3 !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL reset_mid_valid: resp_valid=1 seen, required 0");
        end
        reset = 1'b0;
        do_req(0, 0, 0, 32'h20, 32'h0, rd, er);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL reset_mid_nowrite: rdata=%h, required 1", rd);
        end
    endtask

    task automatic test_stall();
        logic [3:0] st, vl;
        @(negedge clk);
        we = 1'b0; bt = 1'b0; addr = 32'h10; rv3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            st[i] = stall3;
            vl[i] = valid3;
            if (i == 3) rv3 = 1'b0;
            else @(negedge clk);
        end
        checks++;
        if (st !== 4'b0111 || vl !== 4'b1000) begin
            errors++;
            $display("FAIL stall_seq: stall(c3..c0)=%b valid=%b, required 0111 1000", st, vl);
        end
        #1;
        checks++;
        if (stall3 !== 1'b0) begin
            errors++; $display("FAIL stall_idle: stall=%b, required 0", stall3);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_rd, by;
        logic er, exp_er;
        int idx, lane;
        bit w, b;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            a = ($urandom & 32'hFFFF_FF00) | 32'h80 | (i << 2);
            do_req(0, 1, 0, a, d, rd, er);
            model[32 + i] = d;
        end
        for (int n = 0; n < 40; n++) begin
            idx  = $urandom_range(0, 15);
            lane = $urandom_range(0, 3);
            w    = 1'($urandom_range(0, 1));
            b    = 1'($urandom_range(0, 1));
            a    = ($urandom & 32'hFFFF_FF00) | 32'h80 | (idx << 2) | lane;
            d    = $urandom;
            exp_rd = 32'h0;
            exp_er = (!b && lane != 0);
            if (!exp_er) begin
                if (w) begin
                    if (b)
                        model[32 + idx] = (model[32 + idx] & ~(32'hFF << (8 * lane)))
                                        | ((d & 32'hFF) << (8 * lane));
                    else
                        model[32 + idx] = d;
                end else if (b) begin
                    by = (model[32 + idx] >> (8 * lane)) & 32'hFF;
                    exp_rd = (by >= 128) ? (by | 32'hFFFF_FF00) : by;
                end else begin
                    exp_rd = model[32 + idx];
                end
            end
            do_req(0, w, b, a, d, rd, er);
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL random %0d (we=%0d byte=%0d addr=%h): rdata=%h err=%b, required %h %b",
                         n, w, b, a, rd, er, exp_rd, exp_er);
            end
        end
        for (int i = 0; i < 16; i++) begin
            do_req(0, 0, 0, 32'h80 | (i << 2), 32'h0, rd, er);
            checks++;
            if (rd !== model[32 + i]) begin
                errors++;
                $display("FAIL readback word %0d: rdata=%h, required %h", 32 + i, rd, model[32 + i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rv3 = 1'b0; rv1 = 1'b0; we = 1'b0; bt = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
